// File: rtl/gf2_systemizer_stream.sv
// Streaming GF(2) systemizer: loads N_ROWS rows, reduces the leftmost N_ROWS
// columns to identity by pivot search, swap and parallel XOR elimination, then drains.
module gf2_systemizer_stream #(
    parameter int N_ROWS = 4,
    parameter int N_COLS = 8,
    parameter int CYC_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_COLS-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_COLS-1:0] out_data,
    output logic              done,
    output logic              fail,
    output logic [CYC_W-1:0]  cycles
);

    localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam logic [RW-1:0] LAST = RW'(N_ROWS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEARCH,
        SWAP,
        ELIM,
        DRAIN,
        DONE
    } state_t;

    state_t            state;
    logic [N_COLS-1:0] mat [N_ROWS];
    logic [RW-1:0]     idx;
    logic [RW-1:0]     r;
    logic [RW-1:0]     c;
    logic [RW-1:0]     k;
    logic [N_ROWS-1:0] piv_col;

    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        return (&v) ? v : v + CYC_W'(1);
    endfunction

    // Bit c of every row: drives both the pivot search and the elimination mask.
    always_comb begin
        piv_col = '0;
        for (int i = 0; i < N_ROWS; i++) begin
            for (int j = 0; j < N_ROWS; j++) begin
                if (RW'(j) == c) piv_col[i] = mat[i][j];
            end
        end
    end

    // Matrix storage carries no reset; its contents only matter after a LOAD.
    always_ff @(posedge clk) begin
        case (state)
            LOAD: begin
                if (in_valid && in_ready) mat[idx] <= in_data;
            end
            SWAP: begin
                mat[r] <= mat[c];
                mat[c] <= mat[r];
            end
            ELIM: begin
                for (int i = 0; i < N_ROWS; i++) begin
                    if (RW'(i) != c && piv_col[i]) mat[i] <= mat[i] ^ mat[c];
                end
            end
            default: ;
        endcase
    end

    assign out_data = out_valid ? mat[k] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            r         <= '0;
            c         <= '0;
            k         <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            cycles    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= LOAD;
                        fail     <= 1'b0;
                        cycles   <= '0;
                        idx      <= '0;
                        in_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready) begin
                        idx <= idx + RW'(1);
                        if (idx == LAST) begin
                            state    <= SEARCH;
                            in_ready <= 1'b0;
                            c        <= '0;
                            r        <= '0;
                        end
                    end
                end
                SEARCH: begin
                    cycles <= sat_inc(cycles);
                    if (piv_col[r]) begin
                        state <= SWAP;
                    end else if (r == LAST) begin
                        fail      <= 1'b1;
                        state     <= DRAIN;
                        k         <= '0;
                        out_valid <= 1'b1;
                    end else begin
                        r <= r + RW'(1);
                    end
                end
                SWAP: begin
                    cycles <= sat_inc(cycles);
                    state  <= ELIM;
                end
                ELIM: begin
                    cycles <= sat_inc(cycles);
                    if (c == LAST) begin
                        state     <= DRAIN;
                        k         <= '0;
                        out_valid <= 1'b1;
                    end else begin
                        c     <= c + RW'(1);
                        r     <= c + RW'(1);
                        state <= SEARCH;
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        k <= k + RW'(1);
                        if (k == LAST) begin
                            out_valid <= 1'b0;
                            state     <= DONE;
                            done      <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gf2_systemizer_stream.sv
// Directed bench for gf2_systemizer_stream: identity, swap, singular,
// backpressure, mid-operation reset and ignored start pulses.
module tb_gf2_systemizer_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        done;
    logic        fail;
    logic [15:0] cycles;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gf2_systemizer_stream #(.N_ROWS(4), .N_COLS(8), .CYC_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .done     (done),
        .fail     (fail),
        .cycles   (cycles)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge while IDLE; returns at the negedge after LOAD is entered.
    task automatic start_op(input string name);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_start_accepted"}, 32'(in_ready), 32'd1);
    endtask

    task automatic load_rows(input string name, input logic [31:0] rows, input bit gap);
        int i = 0;
        int n = 0;
        forever begin
            @(negedge clk);
            if (i == 4 || n >= 60) break;
            in_valid = gap ? n[0] : 1'b1;
            in_data  = rows[i*8 +: 8];
            if (in_valid && in_ready) i++;
            n++;
        end
        in_valid = 1'b0;
        check({name, "_load_count"}, 32'(i), 32'd4);
    endtask

    task automatic drain(input string name, input logic [31:0] exp_rows, input logic exp_fail,
                         input logic [15:0] exp_cyc, input bit bp, input bit poke);
        logic [7:0] got [4];
        logic [7:0] held = '0;
        int  k = 0;
        int  n = 0;
        bit  stall = 1'b0;
        bit  poked = 1'b0;
        for (int j = 0; j < 4; j++) got[j] = 'x;
        forever begin
            @(negedge clk);
            start = 1'b0;
            if (k == 4 || n >= 200) break;
            if (poke && out_valid && !poked) begin
                start = 1'b1;
                poked = 1'b1;
            end
            if (stall) begin
                check({name, "_hold"}, 32'(out_data), 32'(held));
                stall = 1'b0;
            end
            out_ready = bp ? (n % 3 == 0) : 1'b1;
            if (out_valid) begin
                if (out_ready) begin
                    got[k] = out_data;
                    k++;
                end else begin
                    stall = 1'b1;
                    held  = out_data;
                end
            end
            n++;
        end
        out_ready = 1'b0;
        check({name, "_drain_count"}, 32'(k), 32'd4);
        for (int j = 0; j < 4; j++)
            check($sformatf("%s_row%0d", name, j), 32'(got[j]), 32'(exp_rows[j*8 +: 8]));
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_out_valid_low"}, 32'(out_valid), 32'd0);
        check({name, "_fail"}, 32'(fail), 32'(exp_fail));
        check({name, "_cycles"}, 32'(cycles), 32'(exp_cyc));
        @(negedge clk);
        check({name, "_done_once"}, 32'(done), 32'd0);
        check({name, "_fail_held"}, 32'(fail), 32'(exp_fail));
        check({name, "_cycles_held"}, 32'(cycles), 32'(exp_cyc));
    endtask

    localparam logic [31:0] T1 = {8'hF8, 8'h34, 8'h52, 8'hA1};
    localparam logic [31:0] T2 = {8'h08, 8'h04, 8'h03, 8'h02};
    localparam logic [31:0] T2_EXP = {8'h08, 8'h04, 8'h02, 8'h01};
    localparam logic [31:0] T3 = {8'h08, 8'h04, 8'h01, 8'h01};
    localparam logic [31:0] T3_EXP = {8'h08, 8'h04, 8'h00, 8'h01};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_cycles", 32'(cycles), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Identity prefix
        start_op("t1");
        load_rows("t1", T1, 1'b0);
        drain("t1", T1, 1'b0, 16'd12, 1'b0, 1'b0);

        // Column-0 pivot requires a swap
        start_op("t2");
        load_rows("t2", T2, 1'b0);
        drain("t2", T2_EXP, 1'b0, 16'd13, 1'b0, 1'b0);

        // Singular in column 1
        start_op("t3");
        load_rows("t3", T3, 1'b0);
        drain("t3", T3_EXP, 1'b1, 16'd6, 1'b0, 1'b0);

        // Gapped input, stalling output
        start_op("t4");
        load_rows("t4", T1, 1'b1);
        drain("t4", T1, 1'b0, 16'd12, 1'b1, 1'b0);

        // Reset during the first ELIM of the swap case
        start_op("t5");
        load_rows("t5", T2, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_in_ready", 32'(in_ready), 32'd0);
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_fail", 32'(fail), 32'd0);
        check("t5_cycles", 32'(cycles), 32'd0);
        start_op("t5b");
        load_rows("t5b", T1, 1'b0);
        drain("t5b", T1, 1'b0, 16'd12, 1'b0, 1'b0);

        // Start pulses in SEARCH and DRAIN are ignored; start right after done is taken
        start_op("t6");
        load_rows("t6", T2, 1'b0);
        start = 1'b1;
        drain("t6", T2_EXP, 1'b0, 16'd13, 1'b0, 1'b1);
        start_op("t6b");
        load_rows("t6b", T1, 1'b0);
        drain("t6b", T1, 1'b0, 16'd12, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gf2_systemizer_stream.md
Name: gf2_systemizer_stream

Overview:
Parametrised GF(2) systemizer with streaming row I/O and built-in cycle measurement. It loads an N_ROWS x N_COLS binary matrix row by row and reduces the leftmost N_ROWS columns to identity using pivot search, row swap and parallel XOR elimination. It streams the result out and reports success/singular status and the compute cycle count. It is the successor to the fixed-size, memory-preloaded elimination core and is used standalone or in front of key-generation datapaths.

Parameters:
N_ROWS, 4, matrix rows and number of pivot columns; N_COLS >= N_ROWS is required.
N_COLS, 8, bits per row.
CYC_W, 16, width of the cycle counter output.

Ports:
clk  in  1  clock; all logic is rising-edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle request; honoured only in IDLE.
in_valid  in  1  input row valid.
in_ready  out  1  high only in LOAD.
in_data  in  N_COLS  input row; bit j = column j, so bit 0 is the first pivot column.
out_valid  out  1  output row valid (DRAIN).
out_ready  in  1  sink accepts a row.
out_data  out  N_COLS  result row.
done  out  1  one-cycle pulse at end of operation.
fail  out  1  1 = singular (no pivot found); held from done until next accepted start.
cycles  out  CYC_W  compute cycles; held from done until next accepted start.

Behaviour:
- Reset, including mid-operation: state returns to IDLE. in_ready, out_valid, done, fail, cycles and out_data are 0. Any in-flight operation is abandoned. Matrix storage contents are don't-care.
- States: IDLE, LOAD, SEARCH, SWAP, ELIM, DRAIN, DONE.
- IDLE: start=1 -> LOAD. This clears fail, cycles, the row index and the pivot column c. start in any other state is ignored.
- LOAD: in_ready=1. On each in_valid&&in_ready the row is written to row[idx] and idx increments. After the transfer with idx==N_ROWS-1, go to SEARCH with c=0, r=0.
- SEARCH, one row per cycle:
  - row[r][c]==1 -> SWAP.
  - Otherwise, if r==N_ROWS-1 -> set fail=1 and go to DRAIN.
  - Otherwise r++.
- SWAP, 1 cycle: exchange row[r] and row[c]. When r==c this is a no-op but still takes the cycle. Then go to ELIM.
- ELIM, 1 cycle: every row i != c with row[i][c]==1 is replaced by row[i]^row[c], all in parallel, using pre-cycle values. Then:
  - If c==N_ROWS-1 -> DRAIN.
  - Otherwise c++, r=c+1's value (i.e. r equals the new c), and go to SEARCH.
- Latency: each pivot column costs (rows scanned)+2 cycles. An identity-prefix matrix therefore takes exactly 3*N_ROWS cycles.
- cycles: increments once per cycle spent in SEARCH, SWAP or ELIM. It saturates at 2^CYC_W-1.
- DRAIN:
  - out_valid=1 and out_data=row[k], with k starting at 0.
  - k advances only on out_valid&&out_ready.
  - out_data is stable while stalled.
  - After row N_ROWS-1 is accepted -> DONE. out_valid drops in the same cycle DONE is entered.
- On fail, DRAIN still streams all N_ROWS rows as a partially reduced matrix.
- DONE: done=1 for exactly one cycle, then IDLE. fail and cycles are valid from the done cycle onward.
- Columns >= N_ROWS are carried through all XORs and swaps unchanged in position.

Test Plan:
1. Identity prefix: N_ROWS=4, N_COLS=8, rows 8'hA1, 8'h52, 8'h34, 8'hF8 -> output rows identical, fail=0, cycles=12, one done pulse.
2. Swap needed: rows 8'h02, 8'h03, 8'h04, 8'h08 -> column 0 pivot found at r=1 (swap). Output 8'h01, 8'h02, 8'h04, 8'h08; fail=0; cycles=13.
3. Singular: rows 8'h01, 8'h01, 8'h04, 8'h08 -> column 1 search fails. fail=1, cycles=6, drained rows 8'h01, 8'h00, 8'h04, 8'h08.
4. Backpressure: test 1 with out_ready toggling 1,0,0,1,... and in_valid gapped -> every row transferred exactly once, in order. out_data holds while stalled. cycles is unchanged at 12.
5. Reset mid-ELIM of test 2 (rst high 1 cycle) -> next cycle in_ready=0, out_valid=0, done=0, fail=0, cycles=0. A fresh start plus test 1 data then passes.
6. start pulsed during SEARCH and during DRAIN -> ignored. Exactly one done pulse and correct results; a start in the cycle after done is accepted.
